// File: rtl/hash_sched_if.sv
// Requester, hash-engine and response signals of hash_sched, grouped as one bundle.
// slave = scheduler side, master = requester/engine/consumer side.
interface hash_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [64*NUM_REQ-1:0] req_data;
  logic [6*NUM_REQ-1:0]  req_len;
  logic [63:0]           eng_data;
  logic [5:0]            eng_len;
  logic [9:0]            eng_hash;
  logic                  eng_busy;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [9:0]            rsp_hash;

  modport slave (
    input  req_valid, req_data, req_len, eng_hash, rsp_ready,
    output req_ready, eng_data, eng_len, eng_busy, rsp_valid, rsp_id, rsp_hash
  );

  modport master (
    output req_valid, req_data, req_len, eng_hash, rsp_ready,
    input  req_ready, eng_data, eng_len, eng_busy, rsp_valid, rsp_id, rsp_hash
  );
endinterface

// File: rtl/hash_sched.sv
// Round-robin scheduler sharing one 64-in/10-out hash engine among NUM_REQ requesters.
// Optional macro HASH_SCHED_PRIO0_EN gives requester 0 strict priority over the rotation.
//
// state  | meaning
// S_INIT | engine loading its table after reset, no grants
// S_IDLE | arbitrating, req_ready driven one-hot
// S_WAIT | hash in flight, waiting HASH_LAT cycles
// S_RESP | result presented until rsp_ready
module hash_sched #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int HASH_LAT    = 1,
  parameter int INIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  hash_sched_if.slave  bus
);

  localparam int INIT_W = (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
  localparam logic [3:0]        LAT_LOAD  = 4'(HASH_LAT - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [INIT_W-1:0]   r_init_cnt;
  logic [3:0]          r_lat_cnt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [63:0]         r_eng_data;
  logic [5:0]          r_eng_len;
  logic [ID_W-1:0]     r_rsp_id;
  logic [9:0]          r_rsp_hash;

  logic [ID_W-1:0]     w_grant;
  logic                w_any;
  logic                w_accept;
  logic                w_rr_upd;
  logic [NUM_REQ-1:0]  w_ready;
  logic                w_busy;
  logic                w_rsp_valid;
  logic [63:0]         w_sel_data;
  logic [5:0]          w_sel_len;
  logic [63:0]         w_mask;

  // Search upward from r_rr_ptr; iterating downward lets the nearest requester win.
  always_comb begin : p_grant
    int v_idx;
    v_idx    = 0;
    w_grant  = '0;
    w_any    = 1'b0;
    w_rr_upd = 1'b1;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (bus.req_valid[v_idx]) begin
        w_grant = ID_W'(v_idx);
        w_any   = 1'b1;
      end
    end
`ifdef HASH_SCHED_PRIO0_EN
    if (bus.req_valid[0]) begin
      w_grant  = '0;
      w_rr_upd = 1'b0;
    end
`endif
  end

  assign w_sel_data = bus.req_data[64*int'(w_grant) +: 64];
  assign w_sel_len  = bus.req_len[6*int'(w_grant) +: 6];
  assign w_mask     = (w_sel_len == 6'd0) ? '1 : ((64'd1 << w_sel_len) - 64'd1);
  assign w_accept   = (r_state == S_IDLE) && w_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_INIT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_busy      = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_INIT: if (r_init_cnt == '0) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_any) begin
          w_ready     = NUM_REQ'(1) << w_grant;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (r_lat_cnt == 4'd0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_cnt <= INIT_LOAD;
      r_lat_cnt  <= 4'd0;
      r_rr_ptr   <= '0;
      r_eng_data <= 64'd0;
      r_eng_len  <= 6'd0;
      r_rsp_id   <= '0;
      r_rsp_hash <= 10'd0;
    end else begin
      if (r_state == S_INIT && r_init_cnt != '0)
        r_init_cnt <= r_init_cnt - 1'b1;
      if (w_accept) begin
        r_eng_data <= w_sel_data & w_mask;
        r_eng_len  <= w_sel_len;
        r_rsp_id   <= w_grant;
        r_lat_cnt  <= LAT_LOAD;
        if (w_rr_upd)
          r_rr_ptr <= ID_W'((int'(w_grant) + 1) % NUM_REQ);
      end
      if (r_state == S_WAIT) begin
        if (r_lat_cnt == 4'd0) r_rsp_hash <= bus.eng_hash;
        else                   r_lat_cnt  <= r_lat_cnt - 4'd1;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.eng_data  = r_eng_data;
  assign bus.eng_len   = r_eng_len;
  assign bus.eng_busy  = w_busy;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_hash  = r_rsp_hash;

endmodule

// File: tb/tb_hash_sched.sv
// Directed bench for hash_sched; the engine is an XOR-fold of eng_data into 10 bits.
module tb_hash_sched;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  hash_sched_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  hash_sched #(.NUM_REQ(4), .ID_W(2), .HASH_LAT(1), .INIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.eng_hash = bus.eng_data[9:0] ^ bus.eng_data[19:10] ^ bus.eng_data[29:20] ^
                        bus.eng_data[39:30] ^ bus.eng_data[49:40] ^ bus.eng_data[59:50] ^
                        {6'd0, bus.eng_data[63:60]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester data 1, 2, 3, 0xC05 fold to hashes 1, 2, 3, 6.
  logic [63:0] req_d [4] = '{64'h1, 64'h2, 64'h3, 64'hC05};
  logic [9:0]  req_h [4] = '{10'h1, 10'h2, 10'h3, 10'h6};
`ifdef HASH_SCHED_PRIO0_EN
  int exp_g [5] = '{0, 0, 0, 0, 0};
`else
  int exp_g [5] = '{0, 1, 2, 3, 0};
`endif

  initial begin
    int g;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_data  = {req_d[3], req_d[2], req_d[1], req_d[0]};
    bus.req_len   = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready",    64'(bus.req_ready), 64'd0);
    chk("rst_eng_data", bus.eng_data,       64'd0);
    chk("rst_eng_len",  64'(bus.eng_len),   64'd0);
    chk("rst_busy",     64'(bus.eng_busy),  64'd0);
    chk("rst_rsp_vld",  64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id",   64'(bus.rsp_id),    64'd0);
    chk("rst_rsp_hash", 64'(bus.rsp_hash),  64'd0);

    // Release reset with everyone requesting: two INIT cycles, then grant 0.
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    #1 chk("init_c0_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    #1 chk("init_c1_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);

    // Continuous requests, rsp_ready high: one accept every 3 cycles.
    for (int i = 0; i < 5; i++) begin
      g = exp_g[i];
      #1 chk($sformatf("rr%0d_ready", i), 64'(bus.req_ready), 64'(4'b0001 << g));
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_busy", i), 64'(bus.eng_busy), 64'd1);
      chk($sformatf("rr%0d_data", i), bus.eng_data, req_d[g]);
      chk($sformatf("rr%0d_rdy0", i), 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_rsp_vld", i),  64'(bus.rsp_valid), 64'd1);
      chk($sformatf("rr%0d_rsp_id", i),   64'(bus.rsp_id),    64'(g));
      chk($sformatf("rr%0d_rsp_hash", i), 64'(bus.rsp_hash),  64'(req_h[g]));
      @(negedge clk);
    end

    // Length masking on requester 2.
    bus.req_valid = 4'b0100;
    bus.req_data[128 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.req_len[12 +: 6]    = 6'd4;
    #1 chk("mask_ready", 64'(bus.req_ready), 64'h4);
    @(negedge clk);
    #1;
    chk("mask_eng_data", bus.eng_data,     64'h000F);
    chk("mask_eng_len",  64'(bus.eng_len), 64'd4);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;

    // Response stalled for 5 cycles: everything holds, no new grant.
    for (int j = 0; j < 5; j++) begin
      #1;
      chk($sformatf("stall%0d_vld", j),   64'(bus.rsp_valid), 64'd1);
      chk($sformatf("stall%0d_id", j),    64'(bus.rsp_id),    64'd2);
      chk($sformatf("stall%0d_hash", j),  64'(bus.rsp_hash),  64'h00F);
      chk($sformatf("stall%0d_ready", j), 64'(bus.req_ready), 64'd0);
      chk($sformatf("stall%0d_data", j),  bus.eng_data,       64'h000F);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1000;
    #1 chk("stall_end_vld", 64'(bus.rsp_valid), 64'd1);
    @(negedge clk);
    #1;
    chk("post_stall_ready", 64'(bus.req_ready), 64'h8);
    chk("post_stall_vld",   64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("pre_rst_busy", 64'(bus.eng_busy), 64'd1);
    chk("pre_rst_data", bus.eng_data,      64'hC05);

    // Async reset during WAIT drops the request and repeats INIT.
    bus.req_valid = 4'b0000;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy",   64'(bus.eng_busy),  64'd0);
    chk("mid_rst_data",   bus.eng_data,       64'd0);
    chk("mid_rst_rsp_id", 64'(bus.rsp_id),    64'd0);
    chk("mid_rst_vld",    64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("reinit_c0_ready", 64'(bus.req_ready), 64'd0);
    chk("reinit_c0_vld",   64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("reinit_c1_ready", 64'(bus.req_ready), 64'd0);
    chk("reinit_c1_vld",   64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    #1 chk("reinit_c2_ready", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    #1 chk("reinit_data", bus.eng_data, 64'h1);
    @(negedge clk);
    #1;
    chk("reinit_rsp_vld",  64'(bus.rsp_valid), 64'd1);
    chk("reinit_rsp_id",   64'(bus.rsp_id),    64'd0);
    chk("reinit_rsp_hash", 64'(bus.rsp_hash),  64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_sched.md
# hash_sched

Round-robin scheduler that shares one 64-bit-in/10-bit-out hash engine among `NUM_REQ` lookup requesters (PIT, FIB, CS, …) in the NDN router datapath. It arbitrates valid/ready requests and drives the engine's `data`/`len` inputs from a register. It samples the engine's `hash` after a fixed latency and returns the result tagged with the requester index. It also holds off all traffic for the engine's post-reset table-load window.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of requester index, ≥ clog2(`NUM_REQ`).
- `HASH_LAT`, 1: cycles from engine input change to stable `hash`, 1..15.
- `INIT_CYCLES`, 2: cycles after reset release during which the engine is loading its table.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `req_valid` in `NUM_REQ`: per-requester request strobe.
- `req_ready` out `NUM_REQ`: per-requester accept, one-hot or zero.
- `req_data` in 64×`NUM_REQ`: name bits; requester i occupies `[64i+63:64i]`.
- `req_len` in 6×`NUM_REQ`: valid bit count; 0 means all 64.
- `eng_data` out 64: registered data to the hash engine.
- `eng_len` out 6: registered length to the hash engine.
- `eng_hash` in 10: hash engine result.
- `eng_busy` out 1: high while a hash is in flight (WAIT state).
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accept.
- `rsp_id` out `ID_W`: index of the requester the result belongs to.
- `rsp_hash` out 10: captured hash.

## Operation
- FSM states: INIT → IDLE → WAIT → RESP → IDLE.
- INIT: counter loads `INIT_CYCLES`-1 and decrements each cycle; move to IDLE when it reaches 0. `req_ready` = 0 throughout.
- IDLE: grant goes to the first asserted `req_valid` searching upward from `rr_ptr`, modulo `NUM_REQ`. `req_ready[g]` = 1 combinationally, only in IDLE.
- On accept (`req_valid[g]` & `req_ready[g]`):
  - `eng_data` ← `req_data[g]` with bits at positions ≥ `req_len[g]` forced to 0 (no masking when len = 0).
  - `eng_len` ← `req_len[g]`; `rsp_id` ← g; `rr_ptr` ← (g+1) mod `NUM_REQ`.
  - latency counter ← `HASH_LAT`-1; go to WAIT.
- WAIT: `eng_busy` = 1. When the counter is 0, `rsp_hash` ← `eng_hash`, go to RESP; otherwise decrement.
- RESP: `rsp_valid` = 1. `rsp_id` and `rsp_hash` stay stable until `rsp_valid` & `rsp_ready`, then go to IDLE.
- `eng_data`/`eng_len` hold their last values outside WAIT and are never changed mid-flight.
- A requester that drops `req_valid` before accept loses nothing. `rr_ptr` advances only on accept.

## Timing
- Reset values: `req_ready` = 0, `eng_data` = 0, `eng_len` = 0, `eng_busy` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_hash` = 0, `rr_ptr` = 0, state = INIT.
- The first accept is possible in cycle `INIT_CYCLES` after `rst` deasserts.
- Latency: accept in cycle T → `eng_data` valid from T+1 → `rsp_valid` high in T+1+`HASH_LAT`.
- Response handshake in cycle R → IDLE in R+1; earliest next accept is R+1.
- Sustained throughput is one request per `HASH_LAT`+2 cycles with `rsp_ready` tied high.
- Reset asserted mid-operation: all state returns to reset values immediately and the in-flight request is dropped. The INIT wait repeats, because the engine reloads its table too.

## Configuration
- `HASH_SCHED_PRIO0_EN`:
  - Defined: requester 0 has strict priority. If `req_valid[0]` is high in IDLE it is granted regardless of `rr_ptr`, and `rr_ptr` is not updated. Requesters 1..`NUM_REQ`-1 rotate round-robin among themselves.
  - Undefined: pure round-robin across all requesters, as described above.

## Test plan
- Reset release with `req_valid` = 4'b1111 → `req_ready` stays 0 for 2 cycles, then `req_ready` = 4'b0001 in cycle 2.
- All four valid continuously, `rsp_ready` = 1 → grant order 0,1,2,3,0, with accepts every 3 cycles.
- Req 2 with data = 64'hFFFF_FFFF_FFFF_FFFF and len = 4 → `eng_data` = 64'h000F, `rsp_id` = 2, and `rsp_hash` equals the engine output for 64'h000F.
- `rsp_ready` = 0 for 5 cycles during RESP → `rsp_valid`/`rsp_id`/`rsp_hash` stable, `req_ready` = 0, and no new accept until the handshake.
- `rst` pulsed low during WAIT → outputs reset within the same cycle, and the pending request is not returned after INIT.
- With `HASH_SCHED_PRIO0_EN`, req 0 and req 1 continuously valid → req 0 is granted every time and req 1 is never granted.
